irq_ack_dispatch: RTL and testbench

Acknowledge dispatcher for the 27-channel, three-bus priority interrupt controller. It sits downstream of the combinational priority/channel encoder and consumes that encoder's bus flags (PA, PB, PC) and 4-bit channel code (Chan). It decodes the code back into a single requester and drives a registered one-hot acknowledge to that requester. It holds the acknowledge until the requester releases its request or a timeout expires, then inserts a hold-off gap before accepting the next grant.

---
 rtl/irq_ack_dispatch.sv | 175 +++++++++++++++++
 tb/tb_irq_ack_dispatch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_ack_dispatch.sv
// Acknowledge dispatcher for the 27-channel, three-bus interrupt controller:
// decodes the encoder's bus flags/channel code and holds a registered one-hot ack.
module irq_ack_dispatch #(
    parameter int unsigned HOLD_MAX = 15,
    parameter int unsigned GAP      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] E,
    input  logic [8:0] A,
    input  logic [8:0] B,
    input  logic [8:0] C,
    input  logic       PA,
    input  logic       PB,
    input  logic       PC,
    input  logic [3:0] Chan,
    output logic [8:0] AckA,
    output logic [8:0] AckB,
    output logic [8:0] AckC,
    output logic [1:0] GrantBus,
    output logic [3:0] GrantChan,
    output logic       Busy,
    output logic       Timeout,
    output logic       Err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_GAP
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] ack_a_q, ack_a_d;
    logic [8:0] ack_b_q, ack_b_d;
    logic [8:0] ack_c_q, ack_c_d;
    logic [1:0] gbus_q, gbus_d;
    logic [3:0] gchan_q, gchan_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;
    logic       err_q, err_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] gap_q, gap_d;

    logic       p_any;
    logic       code_ok;
    logic [3:0] idx;
    logic       hit_a, hit_b, hit_c;
    logic       live;
    logic [8:0] onehot;

    // Chan 1xxx selects channels 0..7, 0000 selects channel 8, anything else is invalid.
    assign p_any   = PA | PB | PC;
    assign code_ok = Chan[3] | (Chan == 4'd0);
    assign idx     = Chan[3] ? {1'b0, Chan[2:0]} : 4'd8;
    assign onehot  = 9'd1 << idx;
    assign hit_a   = PA & E[idx] & A[idx];
    assign hit_b   = PB & E[idx] & B[idx];
    assign hit_c   = PC & E[idx] & C[idx];

    always_comb begin
        live = 1'b0;
        case (gbus_q)
            2'b01:   live = E[gchan_q] & A[gchan_q];
            2'b10:   live = E[gchan_q] & B[gchan_q];
            2'b11:   live = E[gchan_q] & C[gchan_q];
            default: live = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ack_a_d   = ack_a_q;
        ack_b_d   = ack_b_q;
        ack_c_d   = ack_c_q;
        gbus_d    = gbus_q;
        gchan_d   = gchan_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        timeout_d = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (p_any) begin
                    if (!code_ok) begin
                        err_d = 1'b1;
                    end else if (hit_a || hit_b || hit_c) begin
                        // Fixed A, B, C precedence when several buses claim the same channel.
                        gchan_d = idx;
                        cnt_d   = 8'd0;
                        state_d = S_ACK;
                        if (hit_a) begin
                            gbus_d  = 2'b01;
                            ack_a_d = onehot;
                        end else if (hit_b) begin
                            gbus_d  = 2'b10;
                            ack_b_d = onehot;
                        end else begin
                            gbus_d  = 2'b11;
                            ack_c_d = onehot;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ACK: begin
                if (!live || (cnt_q == 8'(HOLD_MAX - 1))) begin
                    // Release wins over timeout when both land on the same cycle.
                    ack_a_d   = 9'd0;
                    ack_b_d   = 9'd0;
                    ack_c_d   = 9'd0;
                    timeout_d = live;
                    if (GAP == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = 8'(GAP);
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_GAP: begin
                gap_d = gap_q - 8'd1;
                if (gap_q <= 8'd1) begin
                    gap_d   = 8'd0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ack_a_q   <= 9'd0;
            ack_b_q   <= 9'd0;
            ack_c_q   <= 9'd0;
            gbus_q    <= 2'b00;
            gchan_q   <= 4'd0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= 8'd0;
            gap_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
            ack_c_q   <= ack_c_d;
            gbus_q    <= gbus_d;
            gchan_q   <= gchan_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
        end
    end

    assign AckA      = ack_a_q;
    assign AckB      = ack_b_q;
    assign AckC      = ack_c_q;
    assign GrantBus  = gbus_q;
    assign GrantChan = gchan_q;
    assign Busy      = busy_q;
    assign Timeout   = timeout_q;
    assign Err       = err_q;

endmodule

// File: tb/tb_irq_ack_dispatch.sv
// Directed bench for irq_ack_dispatch: one instance with HOLD_MAX=4/GAP=1 and one
// with HOLD_MAX=15/GAP=0 driven from the same inputs.
module tb_irq_ack_dispatch;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] E, A, B, C;
    logic       PA, PB, PC;
    logic [3:0] Chan;

    logic [8:0] AckA, AckB, AckC;
    logic [1:0] GrantBus;
    logic [3:0] GrantChan;
    logic       Busy, Timeout, Err;

    logic [8:0] z_AckA, z_AckB, z_AckC;
    logic [1:0] z_GrantBus;
    logic [3:0] z_GrantChan;
    logic       z_Busy, z_Timeout, z_Err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irq_ack_dispatch #(.HOLD_MAX(4), .GAP(1)) u_dut (
        .clk(clk), .rst(rst), .E(E), .A(A), .B(B), .C(C),
        .PA(PA), .PB(PB), .PC(PC), .Chan(Chan),
        .AckA(AckA), .AckB(AckB), .AckC(AckC),
        .GrantBus(GrantBus), .GrantChan(GrantChan),
        .Busy(Busy), .Timeout(Timeout), .Err(Err)
    );

    irq_ack_dispatch #(.HOLD_MAX(15), .GAP(0)) u_dut_nogap (
        .clk(clk), .rst(rst), .E(E), .A(A), .B(B), .C(C),
        .PA(PA), .PB(PB), .PC(PC), .Chan(Chan),
        .AckA(z_AckA), .AckB(z_AckB), .AckC(z_AckC),
        .GrantBus(z_GrantBus), .GrantChan(z_GrantChan),
        .Busy(z_Busy), .Timeout(z_Timeout), .Err(z_Err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        E = 9'h1FF; A = 9'h0; B = 9'h0; C = 9'h0;
        PA = 1'b0; PB = 1'b0; PC = 1'b0; Chan = 4'd0;
    endtask

    function automatic logic [31:0] all_out();
        return {AckA[4:0], AckB, AckC, GrantBus, GrantChan, Busy, Timeout, Err} | {27'd0, AckA[8:5]} << 28;
    endfunction

    initial begin
        // Reset with random inputs
        rst = 1'b1;
        E = 9'($urandom); A = 9'($urandom); B = 9'($urandom); C = 9'($urandom);
        PA = 1'b1; PB = 1'b1; PC = 1'b1; Chan = 4'($urandom);
        step();
        check("rst1_acks", {5'd0, AckA, AckB, AckC}, 32'd0);
        check("rst1_misc", {GrantBus, GrantChan, Busy, Timeout, Err}, 32'd0);
        step();
        check("rst2_acks", {5'd0, AckA, AckB, AckC}, 32'd0);
        check("rst2_misc", {GrantBus, GrantChan, Busy, Timeout, Err}, 32'd0);
        rst = 1'b0;
        idle_inputs();
        step();

        // Grant on bus A, channel 8
        A = 9'h100; PA = 1'b1; Chan = 4'b0000;
        step();
        check("a8_ack", AckA, 9'h100);
        check("a8_bus", GrantBus, 2'b01);
        check("a8_chan", GrantChan, 4'd8);
        check("a8_busy", Busy, 1'b1);
        PA = 1'b0; A = 9'h0;
        step();
        check("a8_rel_ack", AckA, 9'h0);
        check("a8_rel_busy", Busy, 1'b1);
        check("a8_rel_to", Timeout, 1'b0);
        step();
        check("a8_gap_busy", Busy, 1'b0);
        check("a8_hold_bus", GrantBus, 2'b01);
        check("a8_hold_chan", GrantChan, 4'd8);

        // Bus order: A flagged but idle at idx 5, B wins
        A = 9'h000; B = 9'h020; PA = 1'b1; PB = 1'b1; Chan = 4'b1101;
        step();
        check("ord_ackb", AckB, 9'h020);
        check("ord_acka", AckA, 9'h000);
        check("ord_bus", GrantBus, 2'b10);
        check("ord_chan", GrantChan, 4'd5);
        B = 9'h0; PA = 1'b0; PB = 1'b0;
        step();
        check("ord_rel", AckB, 9'h0);
        step();

        // Timeout on bus C channel 0 with the request held
        C = 9'h001; PC = 1'b1; Chan = 4'b1000;
        step();
        check("to_ack0", AckC, 9'h001);
        PC = 1'b0;
        // A competing request must be ignored while acknowledging
        A = 9'h001; PA = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            check($sformatf("to_ack%0d", i), AckC, 9'h001);
            check($sformatf("to_pulse%0d", i), Timeout, 1'b0);
        end
        check("to_ignore_a", AckA, 9'h000);
        PA = 1'b0; A = 9'h0;
        step();
        check("to_fall", AckC, 9'h000);
        check("to_pulse", Timeout, 1'b1);
        check("to_busy", Busy, 1'b1);
        step();
        check("to_pulse_end", Timeout, 1'b0);
        check("to_idle", Busy, 1'b0);
        C = 9'h0;

        // Invalid code
        A = 9'h1FF; PA = 1'b1; Chan = 4'b0011;
        step();
        check("inv_err", Err, 1'b1);
        check("inv_ack", AckA, 9'h0);
        check("inv_busy", Busy, 1'b0);
        PA = 1'b0;
        step();
        check("inv_err_end", Err, 1'b0);

        // Valid code but no matching request
        A = 9'h000; PA = 1'b1; Chan = 4'b1010;
        step();
        check("empty_err", Err, 1'b1);
        check("empty_ack", AckA, 9'h0);
        PA = 1'b0;
        step();
        check("empty_err_end", Err, 1'b0);

        // Request present but channel disabled
        E = 9'h1F7; A = 9'h008; PA = 1'b1; Chan = 4'b1011;
        step();
        check("dis_err", Err, 1'b1);
        check("dis_ack", AckA, 9'h0);
        idle_inputs();
        step();

        // Reset in the middle of an acknowledge
        A = 9'h010; PA = 1'b1; Chan = 4'b1100;
        step();
        check("mid_ack", AckA, 9'h010);
        rst = 1'b1;
        step();
        check("mid_rst_ack", AckA, 9'h000);
        check("mid_rst_misc", {GrantBus, GrantChan, Busy, Timeout, Err}, 32'd0);
        rst = 1'b0;
        PA = 1'b0;
        step();

        // Release sampled when the hold counter is at HOLD_MAX-1
        PA = 1'b1;
        step();
        check("race_ack0", AckA, 9'h010);
        PA = 1'b0;
        step(); step(); step();
        check("race_ack3", AckA, 9'h010);
        A = 9'h000;
        step();
        check("race_fall", AckA, 9'h000);
        check("race_to", Timeout, 1'b0);
        check("race_busy", Busy, 1'b1);
        step();

        // Back-to-back grants with GAP=0 versus GAP=1 hold-off
        rst = 1'b1;
        step();
        rst = 1'b0;
        A = 9'h001; PA = 1'b1; Chan = 4'b1000;
        step();
        check("b2b_z_ack0", z_AckA, 9'h001);
        check("b2b_g_ack0", AckA, 9'h001);
        A = 9'h002; Chan = 4'b1001;
        step();
        check("b2b_z_fall", z_AckA, 9'h000);
        check("b2b_z_busy", z_Busy, 1'b0);
        check("b2b_g_fall", AckA, 9'h000);
        step();
        check("b2b_z_ack1", z_AckA, 9'h002);
        check("b2b_z_chan", z_GrantChan, 4'd1);
        check("b2b_g_holdoff", AckA, 9'h000);
        step();
        check("b2b_g_ack1", AckA, 9'h002);
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
